// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide over sign-stripped magnitudes, with a start/busy/done handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam logic [4:0] OP_MUL  = 5'b01010;
    localparam logic [4:0] OP_REMU = 5'b10001;
    localparam int         CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;        // 0 mul .. 7 remu
    logic [2*XLEN-1:0]   acc_q;       // multiply: {hi, lo}; divide: low half = dividend/quotient
    logic [XLEN-1:0]     bmag_q;
    logic [XLEN:0]       rem_q;
    logic                neg_q;
    logic                negr_q;
    logic [XLEN-1:0]     result_q;
    logic                done_q;

    // Acceptance-side decode
    logic [2:0]      op_idx;
    logic            op_ok, a_sgn, b_sgn, a_neg, b_neg, is_div, is_rem, div_by0, ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;

    always_comb begin
        op_idx  = 3'(alu_op_i - OP_MUL);
        op_ok   = (alu_op_i >= OP_MUL) && (alu_op_i <= OP_REMU);
        a_sgn   = (op_idx == 3'd0) || (op_idx == 3'd1) || (op_idx == 3'd2) ||
                  (op_idx == 3'd4) || (op_idx == 3'd6);
        b_sgn   = (op_idx == 3'd0) || (op_idx == 3'd1) ||
                  (op_idx == 3'd4) || (op_idx == 3'd6);
        a_neg   = a_sgn & a_i[XLEN-1];
        b_neg   = b_sgn & b_i[XLEN-1];
        a_mag   = a_neg ? -a_i : a_i;
        b_mag   = b_neg ? -b_i : b_i;
        is_div  = op_idx[2];
        is_rem  = op_idx[2] & op_idx[1];
        div_by0 = (b_i == '0);
        ovf     = a_sgn && (a_i == MIN_INT) && (b_i == '1);
        if (is_rem) spec_res = div_by0 ? a_i : '0;
        else        spec_res = div_by0 ? '1 : MIN_INT;
    end

    // One iteration step for both datapaths
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   mul_sh;
    logic [XLEN+1:0]   div_sh, div_diff;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN:0]     rem_d;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
        mul_sh   = {mul_sum, acc_q[XLEN-1:0]} >> 1;
        div_sh   = {rem_q, acc_q[XLEN-1]};
        div_diff = div_sh - {2'b00, bmag_q};
        if (op_q[2]) begin
            // Borrow set means the shifted remainder is below the divisor: restore.
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN+1]};
            rem_d = div_diff[XLEN+1] ? div_sh[XLEN:0] : div_diff[XLEN:0];
        end else begin
            acc_d = mul_sh[2*XLEN-1:0];
            rem_d = rem_q;
        end
    end

    // Sign fix-up and output selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_res;

    always_comb begin
        prod = neg_q  ? -acc_q : acc_q;
        quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rmd  = negr_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (op_q)
            3'd0:             fix_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = quo;
            default:          fix_res = rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !flush_i && op_ok) begin
                        op_q   <= op_idx;
                        neg_q  <= a_neg ^ b_neg;
                        negr_q <= a_neg;
                        bmag_q <= b_mag;
                        acc_q  <= {{XLEN{1'b0}}, a_mag};
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        if (is_div && (div_by0 || ovf)) begin
                            result_q <= spec_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP) state_q <= FIX;
                    end
                end
                FIX: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
endmodule
